instr_exec: RTL

Execution stage directly downstream of `instr_register`. On a start command it walks the register by driving `read_pointer`, latches each returned `instruction_word`, and computes the operation result. It presents each result on a valid/ready output port for a scoreboard or writeback consumer. It handles one instruction at a time through a small FSM, with backpressure and divide-by-zero flagging.

---
 rtl/instr_register_pkg.sv | 34 +++
 rtl/instr_exec_alu.sv | 42 ++++
 rtl/instr_exec.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
//   opcode_t      : operation selector
//   operand_t     : signed 32-bit operand
//   address_t     : 5-bit instruction register address
//   instruction_t : packed {opc, op_a, op_b} as stored in instr_register
//   result_t      : signed 64-bit execution result
//   exec_state_t  : instr_exec control states
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, OUT, FINISH
  } exec_state_t;

  // Widen an operand to result width, preserving its sign.
  function automatic result_t sext_operand(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_exec_alu.sv
// instr_alu: purely combinational operation unit.
//   opc, op_a, op_b : decoded instruction fields
//   result          : 64-bit signed outcome of the operation
//   div_by_zero     : DIV/MOD attempted with op_b == 0 (result forced to 0)
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result,
  output logic     div_by_zero
);

  result_t a;
  result_t b;

  always_comb begin
    a           = sext_operand(op_a);
    b           = sext_operand(op_b);
    result      = '0;
    div_by_zero = 1'b0;
    unique case (opc)
      ZERO:  result = '0;
      PASSA: result = a;
      PASSB: result = b;
      ADD:   result = a + b;
      SUB:   result = a - b;
      MULT:  result = a * b;
      DIV: begin
        if (b == '0) div_by_zero = 1'b1;
        else         result      = a / b;
      end
      MOD: begin
        if (b == '0) div_by_zero = 1'b1;
        else         result      = a % b;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec.sv
// instr_exec: execution stage that walks instr_register from start_addr for
// count entries, executes each instruction and offers the result on a
// valid/ready port.
//   clk, reset          : clock, asynchronous active-high reset
//   start, start_addr,
//   count               : run request (sampled only when idle)
//   read_pointer        : address presented to instr_register (registered)
//   instruction_word    : combinational read data at read_pointer
//   res_valid/res_ready : result handshake
//   res_addr, res_opc,
//   result, div_by_zero : result payload, held while res_valid && !res_ready
//   busy, done          : run in progress / one-cycle run completion pulse
module instr_exec
  import instr_register_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 32
)
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_addr,
  output opcode_t      res_opc,
  output result_t      result,
  output logic         div_by_zero,
  output logic         busy,
  output logic         done
);

  exec_state_t  state_q, state_d;
  address_t     read_pointer_q, read_pointer_d;
  logic [5:0]   remaining_q, remaining_d;
  instruction_t instr_q, instr_d;
  address_t     tag_q, tag_d;
  logic         res_valid_q, res_valid_d;
  address_t     res_addr_q, res_addr_d;
  opcode_t      res_opc_q, res_opc_d;
  result_t      result_q, result_d;
  logic         div_by_zero_q, div_by_zero_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  result_t      alu_result;
  logic         alu_div_by_zero;
  address_t     pointer_inc;

  instr_alu u_alu (
    .opc         (instr_q.opc),
    .op_a        (instr_q.op_a),
    .op_b        (instr_q.op_b),
    .result      (alu_result),
    .div_by_zero (alu_div_by_zero)
  );

  // Wrap modulo the register depth.
  assign pointer_inc = address_t'((32'(read_pointer_q) + 32'd1) % NUM_INSTR);

  always_comb begin
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    instr_d        = instr_q;
    tag_d          = tag_q;
    res_valid_d    = res_valid_q;
    res_addr_d     = res_addr_q;
    res_opc_d      = res_opc_q;
    result_d       = result_q;
    div_by_zero_d  = div_by_zero_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          read_pointer_d = start_addr;
          remaining_d    = count;
          busy_d         = 1'b1;
          if (count == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        tag_d   = read_pointer_q;
        state_d = EXEC;
      end
      EXEC: begin
        result_d      = alu_result;
        div_by_zero_d = alu_div_by_zero;
        res_addr_d    = tag_q;
        res_opc_d     = instr_q.opc;
        res_valid_d   = 1'b1;
        state_d       = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d    = 1'b0;
          read_pointer_d = pointer_inc;
          remaining_d    = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      read_pointer_q <= '0;
      remaining_q    <= '0;
      instr_q        <= '0;
      tag_q          <= '0;
      res_valid_q    <= 1'b0;
      res_addr_q     <= '0;
      res_opc_q      <= ZERO;
      result_q       <= '0;
      div_by_zero_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      instr_q        <= instr_d;
      tag_q          <= tag_d;
      res_valid_q    <= res_valid_d;
      res_addr_q     <= res_addr_d;
      res_opc_q      <= res_opc_d;
      result_q       <= result_d;
      div_by_zero_q  <= div_by_zero_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign read_pointer = read_pointer_q;
  assign res_valid    = res_valid_q;
  assign res_addr     = res_addr_q;
  assign res_opc      = res_opc_q;
  assign result       = result_q;
  assign div_by_zero  = div_by_zero_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
